sm_trace_capture: RTL and testbench

- Synthesizable instruction-trace recorder for sm_cpu.
- Samples {cycle, pc, instr, watched register value} on every enabled CPU cycle into an on-chip buffer.
- Stops capture on timeout, a halt idiom, or buffer full, and exposes a valid/ready drain port.
- Sits beside sm_cpu in sm_top. The watched value is the regData debug read driven by regAddr, for example x10 (a0).

---
 rtl/sm_trace_capture.sv | 165 ++++++++++++++++
 tb/tb_sm_trace_capture.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_trace_capture.sv
// rtl/sm_trace_capture.sv - instruction-trace recorder for sm_cpu with valid/ready drain port
module sm_trace_capture #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_LOG2  = 4,
    parameter int CYCLE_WIDTH = 16,
    parameter int TIMEOUT     = 120,
    parameter int HALT_REPEAT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   start,
    input  logic                   clear,
    input  logic                   mode,
    input  logic [ADDR_WIDTH-1:0]  pc,
    input  logic [31:0]            instr,
    input  logic [31:0]            regData,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [CYCLE_WIDTH-1:0] rd_cycle,
    output logic [ADDR_WIDTH-1:0]  rd_pc,
    output logic [31:0]            rd_instr,
    output logic [31:0]            rd_data,
    output logic [DEPTH_LOG2:0]    count,
    output logic [1:0]             state,
    output logic                   timeout,
    output logic                   halted,
    output logic                   overflow
);
    localparam int DEPTH   = 2 ** DEPTH_LOG2;
    localparam int ENTRY_W = CYCLE_WIDTH + ADDR_WIDTH + 64;
    localparam int REP_W   = $clog2(HALT_REPEAT + 1);
    localparam logic [CYCLE_WIDTH-1:0] CYC_LAST = CYCLE_WIDTH'(TIMEOUT - 1);
    localparam logic [REP_W-1:0]       REP_HALT = REP_W'(HALT_REPEAT);
    localparam logic [DEPTH_LOG2:0]    FULL     = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [31:0]            IDIOM    = 32'h0000_0063;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_STOPPED = 2'd2
    } state_t;

    state_t                 state_q;
    logic [ENTRY_W-1:0]     mem [DEPTH];
    logic [ENTRY_W-1:0]     head_q, head_d, entry_in;
    logic [DEPTH_LOG2-1:0]  rptr_q, rptr_d, wptr_q, wptr_d;
    logic [DEPTH_LOG2:0]    count_q, count_d;
    logic [CYCLE_WIDTH-1:0] cyc_q;
    logic [REP_W-1:0]       rep_q, rep_d;
    logic [ADDR_WIDTH-1:0]  last_pc_q;
    logic                   timeout_q, halted_q, overflow_q;
    logic                   sample, pop, full, push, overwrite;
    logic                   hit_halt, hit_to, hit_full;

    assign entry_in = {cyc_q, pc, instr, regData};

    always_comb begin
        sample    = (state_q == S_CAPTURE) && en && !clear;
        pop       = (count_q != '0) && rd_ready && !clear;
        full      = (count_q == FULL);
        // In stop-when-full mode a full buffer never accepts a sample it cannot hold.
        push      = sample && !(full && !pop && !mode);
        overwrite = push && full && !pop;
        rptr_d    = (pop || overwrite) ? rptr_q + 1'b1 : rptr_q;
        wptr_d    = push ? wptr_q + 1'b1 : wptr_q;
        count_d   = count_q;
        if (push && !pop && !full) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        // Head register tracks the entry at the new read pointer, bypassing a same-clk write.
        head_d = (push && (wptr_q == rptr_d)) ? entry_in : mem[rptr_d];
        rep_d  = '0;
        if (instr == IDIOM) begin
            if ((rep_q != '0) && (pc == last_pc_q)) begin
                rep_d = (rep_q == REP_HALT) ? rep_q : rep_q + 1'b1;
            end else begin
                rep_d = REP_W'(1);
            end
        end
        hit_halt = (rep_d == REP_HALT);
        hit_to   = (TIMEOUT != 0) && (cyc_q == CYC_LAST);
        hit_full = !mode && (count_d == FULL);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= entry_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            head_q     <= '0;
            cyc_q      <= '0;
            rep_q      <= '0;
            last_pc_q  <= '0;
            timeout_q  <= 1'b0;
            halted_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            state_q    <= S_IDLE;
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            head_q     <= '0;
            cyc_q      <= '0;
            rep_q      <= '0;
            last_pc_q  <= '0;
            timeout_q  <= 1'b0;
            halted_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            head_q  <= head_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_CAPTURE;
                        cyc_q      <= '0;
                        rep_q      <= '0;
                        timeout_q  <= 1'b0;
                        halted_q   <= 1'b0;
                        overflow_q <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    if (sample) begin
                        if (cyc_q != '1) begin
                            cyc_q <= cyc_q + 1'b1;
                        end
                        rep_q     <= rep_d;
                        last_pc_q <= pc;
                        if (overwrite) overflow_q <= 1'b1;
                        if (hit_to)    timeout_q  <= 1'b1;
                        if (hit_halt)  halted_q   <= 1'b1;
                        if (hit_to || hit_halt || hit_full) begin
                            state_q <= S_STOPPED;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_valid = (count_q != '0);
    assign rd_cycle = head_q[ENTRY_W-1 -: CYCLE_WIDTH];
    assign rd_pc    = head_q[64 +: ADDR_WIDTH];
    assign rd_instr = head_q[32 +: 32];
    assign rd_data  = head_q[31:0];
    assign count    = count_q;
    assign state    = state_q;
    assign timeout  = timeout_q;
    assign halted   = halted_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_sm_trace_capture.sv
// tb/tb_sm_trace_capture.sv - randomized self-checking bench for sm_trace_capture
module tb_sm_trace_capture;
    localparam int D = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        en = 0, start = 0, clear = 0, mode = 0, rd_ready = 0;
    logic [31:0] pc = 0, instr = 0, regData = 0;
    logic        rd_valid, timeout, halted, overflow;
    logic [15:0] rd_cycle;
    logic [31:0] rd_pc, rd_instr, rd_data;
    logic [4:0]  count;
    logic [1:0]  state;

    sm_trace_capture #(.ADDR_WIDTH(32), .DEPTH_LOG2(4), .CYCLE_WIDTH(16),
                       .TIMEOUT(120), .HALT_REPEAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .clear(clear), .mode(mode),
        .pc(pc), .instr(instr), .regData(regData), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_cycle(rd_cycle), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_data(rd_data),
        .count(count), .state(state), .timeout(timeout), .halted(halted), .overflow(overflow));

    logic        b_en = 0, b_start = 0, b_clear = 0, b_mode = 0, b_rd_ready = 0;
    logic [31:0] b_pc = 0, b_instr = 0, b_regData = 0;
    logic        b_rd_valid, b_timeout, b_halted, b_overflow;
    logic [15:0] b_rd_cycle;
    logic [31:0] b_rd_pc, b_rd_instr, b_rd_data;
    logic [4:0]  b_count;
    logic [1:0]  b_state;

    sm_trace_capture #(.ADDR_WIDTH(32), .DEPTH_LOG2(4), .CYCLE_WIDTH(16),
                       .TIMEOUT(8), .HALT_REPEAT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .start(b_start), .clear(b_clear), .mode(b_mode),
        .pc(b_pc), .instr(b_instr), .regData(b_regData), .rd_valid(b_rd_valid),
        .rd_ready(b_rd_ready), .rd_cycle(b_rd_cycle), .rd_pc(b_rd_pc), .rd_instr(b_rd_instr),
        .rd_data(b_rd_data), .count(b_count), .state(b_state), .timeout(b_timeout),
        .halted(b_halted), .overflow(b_overflow));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a queue of samples plus a few scalars, stepped once per clk.
    typedef struct packed {
        logic [15:0] cyc;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    int          m_state = 0;
    int          m_cyc = 0;
    int          m_run = 0;
    bit          m_to = 0, m_halt = 0, m_ovf = 0;
    logic [31:0] m_prev_pc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            mq.delete();
            m_state = 0; m_cyc = 0; m_run = 0;
            m_to = 0; m_halt = 0; m_ovf = 0;
        end else begin
            if (mq.size() > 0 && rd_ready) void'(mq.pop_front());
            if (m_state == 1 && en) begin
                bit   stop;
                ent_t e;
                stop = 0;
                if (mode && mq.size() == D) begin
                    void'(mq.pop_front());
                    m_ovf = 1;
                end
                e = {m_cyc[15:0], pc, instr, regData};
                if (mq.size() < D) mq.push_back(e);
                if (!mode && mq.size() == D) stop = 1;
                if (m_cyc == 119) begin stop = 1; m_to = 1; end
                if (instr == 32'h63) m_run = (m_run > 0 && pc == m_prev_pc) ? m_run + 1 : 1;
                else m_run = 0;
                m_prev_pc = pc;
                if (m_run >= 2) begin stop = 1; m_halt = 1; end
                if (m_cyc < 65535) m_cyc++;
                if (stop) m_state = 2;
            end else if (m_state == 0 && start) begin
                m_state = 1; m_cyc = 0; m_run = 0;
                m_to = 0; m_halt = 0; m_ovf = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            bit   ok;
            ent_t h;
            ok = (rd_valid === (mq.size() > 0)) && (int'(count) == mq.size()) &&
                 (int'(state) == m_state) && (timeout === m_to) &&
                 (halted === m_halt) && (overflow === m_ovf);
            h = '0;
            if (mq.size() > 0) begin
                h = mq[0];
                ok = ok && (rd_cycle === h.cyc) && (rd_pc === h.pc) &&
                     (rd_instr === h.instr) && (rd_data === h.data);
            end
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: state %0d/%0d count %0d/%0d to %0b/%0b halt %0b/%0b ovf %0b/%0b head cyc %0h/%0h pc %0h/%0h",
                         $time, state, m_state, count, mq.size(), timeout, m_to, halted, m_halt,
                         overflow, m_ovf, rd_cycle, h.cyc, rd_pc, h.pc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start(input logic m);
        mode = m; start = 1; tick(); start = 0;
    endtask

    task automatic do_clear();
        clear = 1; tick(); clear = 0;
    endtask

    task automatic push_n(input int n, input logic [31:0] pc0);
        for (int i = 0; i < n; i++) begin
            en = 1; pc = pc0 + 32'(4 * i); instr = $urandom | 32'h100; regData = $urandom;
            tick();
        end
        en = 0;
    endtask

    task automatic drain_check(input string name, input int n, input int cyc0, input logic [31:0] pc0);
        for (int i = 0; i < n; i++) begin
            chk({name, "_valid"}, rd_valid, 1);
            chk({name, "_cycle"}, rd_cycle, cyc0 + i);
            chk({name, "_pc"}, rd_pc, pc0 + 32'(4 * (cyc0 + i)));
            rd_ready = 1; tick(); rd_ready = 0;
        end
        chk({name, "_empty"}, rd_valid, 0);
    endtask

    initial begin
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_count", count, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_rd", {rd_cycle, rd_pc, rd_instr[15:0]}, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_flags", {timeout, halted, overflow}, 0);
        rst_n = 1;
        tick();

        // Timeout instance: mode 1, en on every other clk, 8 samples then stop.
        b_mode = 1; b_start = 1; tick(); b_start = 0;
        for (int i = 0; i < 20; i++) begin
            b_en = (i % 2 == 1); b_pc = 32'(i * 4); b_instr = $urandom | 32'h100;
            b_regData = $urandom;
            tick();
            if (i == 13) chk("to_before", {b_state, b_timeout}, {2'd1, 1'b0});
            if (i == 15) chk("to_after", {b_state, b_timeout}, {2'd2, 1'b1});
        end
        b_en = 0;
        chk("to_count", b_count, 8);
        for (int i = 0; i < 8; i++) begin
            chk("to_cycle", b_rd_cycle, i);
            b_rd_ready = 1; tick(); b_rd_ready = 0;
        end
        chk("to_empty", b_rd_valid, 0);

        do_start(0);
        push_n(10, 0);
        chk("t1_count", count, 10);
        drain_check("t1", 10, 0, 0);
        do_clear();

        do_start(0);
        push_n(20, 32'h1000);
        chk("t2_count", count, 16);
        chk("t2_state", state, 2);
        chk("t2_ovf", overflow, 0);
        drain_check("t2", 16, 0, 32'h1000);
        do_clear();

        do_start(1);
        push_n(20, 32'h2000);
        chk("t3_count", count, 16);
        chk("t3_ovf", overflow, 1);
        chk("t3_state", state, 1);
        drain_check("t3", 16, 4, 32'h2000);
        do_clear();

        do_start(0);
        push_n(3, 32'h100);
        for (int i = 0; i < 3; i++) begin
            en = 1; pc = 32'h20; instr = 32'h63; regData = $urandom;
            tick();
            if (i == 0) chk("halt_first", {state, halted}, {2'd1, 1'b0});
            if (i == 1) chk("halt_second", {state, halted}, {2'd2, 1'b1});
        end
        en = 0;
        chk("halt_count", count, 5);
        rd_ready = 1; tick(); tick(); tick(); tick(); rd_ready = 0;
        chk("halt_last", {rd_pc, rd_cycle}, {32'h20, 16'd4});
        do_clear();

        for (int c = 0; c < 3000; c++) begin
            en = ($urandom_range(0, 3) != 0);
            rd_ready = ($urandom_range(0, 3) == 0);
            start = ($urandom_range(0, 19) == 0);
            clear = ($urandom_range(0, 149) == 0);
            if (m_state == 0 && $urandom_range(0, 7) == 0) mode = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 7) == 0) begin
                pc = 32'h40; instr = 32'h63;
            end else begin
                pc = $urandom; instr = $urandom | 32'h100;
            end
            regData = $urandom;
            tick();
        end
        en = 0; start = 0; clear = 0; rd_ready = 0;
        do_clear();

        do_start(0);
        push_n(5, 0);
        chk("ar_count", count, 5);
        #2 rst_n = 0;
        tick();
        chk("ar_in_reset", {state, count, rd_valid}, 0);
        rst_n = 1;
        clear = 1; start = 1; tick(); clear = 0; start = 0;
        chk("ar_state", state, 0);
        chk("ar_count2", count, 0);
        chk("ar_flags", {timeout, halted, overflow, rd_valid}, 0);
        tick();
        chk("ar_idle", state, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
